// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file arbiter slice.
package regfile_pkg;

    localparam int XLEN = 64;
    localparam int NREG = 32;
    localparam int AW   = 5;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int REQ_CORE = 0;
    localparam int REQ_DBG  = 1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; the lock keeps requester 1 granted across a burst
// as long as it was the most recent winner.
module rr_arbiter2
    import regfile_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       lock,
    input  logic       grant_en,
    output logic [1:0] gnt
);

    // 1 = requester 1 won most recently, so requester 0 wins the first tie
    logic last;

    always_comb begin
        gnt = 2'b00;
        if (grant_en) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = (last && !lock) ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last <= 1'b1;
        end else if (|gnt) begin
            last <= gnt[REQ_DBG];
        end
    end

endmodule

// File: rtl/regfile_arbiter.sv
// Shares the register file between the core datapath and the debug/loader port,
// and zeroes x1..x31 after reset or on a clear request before allowing access.
//
// state | meaning
// INIT  | clear sequencer writes zero to x1..x31, one register per cycle, no grants
// RUN   | clear finished, requests arbitrated round-robin
module regfile_arbiter
    import regfile_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            clr,
    input  logic            r0_req,
    input  logic            r0_we,
    input  logic [AW-1:0]   r0_rs1,
    input  logic [AW-1:0]   r0_rs2,
    input  logic [AW-1:0]   r0_rd,
    input  logic [XLEN-1:0] r0_wdata,
    input  logic            r1_req,
    input  logic            r1_we,
    input  logic [AW-1:0]   r1_rs1,
    input  logic [AW-1:0]   r1_rs2,
    input  logic [AW-1:0]   r1_rd,
    input  logic [XLEN-1:0] r1_wdata,
    input  logic            r1_lock,
    output logic            r0_gnt,
    output logic            r1_gnt,
    output logic [XLEN-1:0] r0_rdata1,
    output logic [XLEN-1:0] r0_rdata2,
    output logic            r0_rvalid,
    output logic [XLEN-1:0] r1_rdata1,
    output logic [XLEN-1:0] r1_rdata2,
    output logic            r1_rvalid,
    output logic [AW-1:0]   rf_rs1,
    output logic [AW-1:0]   rf_rs2,
    output logic [AW-1:0]   rf_rd,
    output logic [XLEN-1:0] rf_WriteData,
    output logic            rf_RegWrite,
    input  logic [XLEN-1:0] rf_ReadData1,
    input  logic [XLEN-1:0] rf_ReadData2,
    output logic            init_done
);

    localparam logic [AW-1:0] LAST_REG = AW'(NREG - 1);

    state_t        state, state_nx;
    logic [AW-1:0] cnt, cnt_nx;
    logic [1:0]    gnt;
    logic          grant_en;

    // clr wins over any request in the cycle it is seen
    assign grant_en  = reset && (state == RUN) && !clr;
    assign r0_gnt    = gnt[REQ_CORE];
    assign r1_gnt    = gnt[REQ_DBG];
    assign init_done = (state == RUN);

    rr_arbiter2 u_arb (
        .clk      (clk),
        .reset    (reset),
        .req      ({r1_req, r0_req}),
        .lock     (r1_lock),
        .grant_en (grant_en),
        .gnt      (gnt)
    );

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            INIT: begin
                if (cnt == LAST_REG) state_nx = RUN;
                else                 cnt_nx   = cnt + AW'(1);
            end
            RUN: begin
                if (clr) begin
                    state_nx = INIT;
                    cnt_nx   = AW'(1);
                end
            end
            default: state_nx = INIT;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= INIT;
            cnt   <= AW'(1);
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        rf_rs1       = '0;
        rf_rs2       = '0;
        rf_rd        = '0;
        rf_WriteData = '0;
        rf_RegWrite  = 1'b0;
        if (state == INIT) begin
            rf_rd       = cnt;
            rf_RegWrite = reset;
        end else if (gnt[REQ_DBG]) begin
            rf_rs1       = r1_rs1;
            rf_rs2       = r1_rs2;
            rf_rd        = r1_rd;
            rf_WriteData = r1_wdata;
            rf_RegWrite  = r1_we && (r1_rd != '0);
        end else if (gnt[REQ_CORE]) begin
            rf_rs1       = r0_rs1;
            rf_rs2       = r0_rs2;
            rf_rd        = r0_rd;
            rf_WriteData = r0_wdata;
            rf_RegWrite  = r0_we && (r0_rd != '0);
        end
    end

    // Read data is the pre-write value: captured at the same edge that commits the write
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r0_rdata1 <= '0;
            r0_rdata2 <= '0;
            r0_rvalid <= 1'b0;
            r1_rdata1 <= '0;
            r1_rdata2 <= '0;
            r1_rvalid <= 1'b0;
        end else begin
            r0_rvalid <= gnt[REQ_CORE];
            r1_rvalid <= gnt[REQ_DBG];
            if (gnt[REQ_CORE]) begin
                r0_rdata1 <= rf_ReadData1;
                r0_rdata2 <= rf_ReadData2;
            end
            if (gnt[REQ_DBG]) begin
                r1_rdata1 <= rf_ReadData1;
                r1_rdata2 <= rf_ReadData2;
            end
        end
    end

endmodule

// File: tb/tb_regfile_arbiter.sv
// Bench for regfile_arbiter: vector table, hand-written corner sequences and
// randomized traffic against an architectural register/arbitration model.
module tb_regfile_arbiter;

    logic        clk, reset, clr;
    logic        r0_req, r0_we, r1_req, r1_we, r1_lock;
    logic [4:0]  r0_rs1, r0_rs2, r0_rd, r1_rs1, r1_rs2, r1_rd;
    logic [63:0] r0_wdata, r1_wdata;
    logic        r0_gnt, r1_gnt, r0_rvalid, r1_rvalid;
    logic [63:0] r0_rdata1, r0_rdata2, r1_rdata1, r1_rdata2;
    logic [4:0]  rf_rs1, rf_rs2, rf_rd;
    logic [63:0] rf_WriteData, rf_ReadData1, rf_ReadData2;
    logic        rf_RegWrite, init_done;

    regfile_arbiter dut (
        .clk(clk), .reset(reset), .clr(clr),
        .r0_req(r0_req), .r0_we(r0_we), .r0_rs1(r0_rs1), .r0_rs2(r0_rs2),
        .r0_rd(r0_rd), .r0_wdata(r0_wdata),
        .r1_req(r1_req), .r1_we(r1_we), .r1_rs1(r1_rs1), .r1_rs2(r1_rs2),
        .r1_rd(r1_rd), .r1_wdata(r1_wdata), .r1_lock(r1_lock),
        .r0_gnt(r0_gnt), .r1_gnt(r1_gnt),
        .r0_rdata1(r0_rdata1), .r0_rdata2(r0_rdata2), .r0_rvalid(r0_rvalid),
        .r1_rdata1(r1_rdata1), .r1_rdata2(r1_rdata2), .r1_rvalid(r1_rvalid),
        .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .rf_rd(rf_rd),
        .rf_WriteData(rf_WriteData), .rf_RegWrite(rf_RegWrite),
        .rf_ReadData1(rf_ReadData1), .rf_ReadData2(rf_ReadData2),
        .init_done(init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External register file with combinational read; preloaded with junk so the clear is visible
    logic        fill_junk;
    logic [63:0] mem [32];
    always @(posedge clk) begin
        if (fill_junk) begin
            for (int i = 0; i < 32; i++) mem[i] <= 64'hBAD0_0000_0000_0000 + 64'(i) + 64'd1;
        end else if (rf_RegWrite) begin
            mem[rf_rd] <= rf_WriteData;
        end
    end
    assign rf_ReadData1 = (rf_rs1 == 5'd0) ? 64'd0 : mem[rf_rs1];
    assign rf_ReadData2 = (rf_rs2 == 5'd0) ? 64'd0 : mem[rf_rs2];

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    logic [63:0] exp_rf [32];
    logic [63:0] exp_rd1 [2];
    logic [63:0] exp_rd2 [2];
    int          last_w;

    typedef struct {
        bit r0, r1, lock, g0, g1;
    } arb_vec_t;
    arb_vec_t tbl [14];

    logic        pend [2];
    logic        t_we [2];
    logic [4:0]  t_rs1 [2], t_rs2 [2], t_rd [2];
    logic [63:0] t_wd [2];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int w, input logic rq, input logic we,
                           input logic [4:0] a1, input logic [4:0] a2,
                           input logic [4:0] d, input logic [63:0] wd);
        if (w == 0) begin
            r0_req = rq; r0_we = we; r0_rs1 = a1; r0_rs2 = a2; r0_rd = d; r0_wdata = wd;
        end else begin
            r1_req = rq; r1_we = we; r1_rs1 = a1; r1_rs2 = a2; r1_rd = d; r1_wdata = wd;
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) exp_rf[i] = 64'd0;
        for (int i = 0; i < 2; i++) begin
            exp_rd1[i] = 64'd0;
            exp_rd2[i] = 64'd0;
        end
        last_w = 1;
    endtask

    // Applies one RUN cycle with the currently driven inputs and checks it against the model
    task automatic model_step(output int win);
        logic        we;
        logic [4:0]  a1, a2, d;
        logic [63:0] wd, e1, e2;
        #1;
        win = -1;
        if (r0_req && r1_req) win = (r1_lock && last_w == 1) ? 1 : 1 - last_w;
        else if (r0_req)      win = 0;
        else if (r1_req)      win = 1;
        we = 1'b0; a1 = 5'd0; a2 = 5'd0; d = 5'd0; wd = 64'd0;
        if (win == 0) begin we = r0_we; a1 = r0_rs1; a2 = r0_rs2; d = r0_rd; wd = r0_wdata; end
        if (win == 1) begin we = r1_we; a1 = r1_rs1; a2 = r1_rs2; d = r1_rd; wd = r1_wdata; end
        chk("gnt0", r0_gnt, win == 0);
        chk("gnt1", r1_gnt, win == 1);
        chk("rf_rs1", rf_rs1, a1);
        chk("rf_regwrite", rf_RegWrite, (win >= 0) && we && (d != 5'd0));
        e1 = exp_rf[a1];
        e2 = exp_rf[a2];
        cyc();
        if (win >= 0) begin
            exp_rd1[win] = e1;
            exp_rd2[win] = e2;
            if (we && d != 5'd0) exp_rf[d] = wd;
            last_w = win;
        end
        chk("r0_rvalid", r0_rvalid, win == 0);
        chk("r1_rvalid", r1_rvalid, win == 1);
        chk("r0_rdata1", r0_rdata1, exp_rd1[0]);
        chk("r0_rdata2", r0_rdata2, exp_rd2[0]);
        chk("r1_rdata1", r1_rdata1, exp_rd1[1]);
        chk("r1_rdata2", r1_rdata2, exp_rd2[1]);
    endtask

    // Expects a full 31-cycle clear starting now, with requests present but ignored
    task automatic init_sweep();
        for (int k = 1; k <= 31; k++) begin
            #1;
            chk("clr_rd", rf_rd, 64'(k));
            chk("clr_we", rf_RegWrite, 1'b1);
            chk("clr_data", rf_WriteData, 64'd0);
            chk("clr_gnt", {r1_gnt, r0_gnt}, 2'b00);
            chk("clr_done", init_done, 1'b0);
            cyc();
        end
        #1;
        chk("init_done", init_done, 1'b1);
        for (int i = 0; i < 32; i++) exp_rf[i] = 64'd0;
    endtask

    initial begin
        int win;
        tbl[0]  = '{1, 1, 0, 1, 0};
        tbl[1]  = '{1, 1, 0, 0, 1};
        tbl[2]  = '{1, 1, 0, 1, 0};
        tbl[3]  = '{1, 1, 0, 0, 1};
        tbl[4]  = '{1, 1, 1, 0, 1};
        tbl[5]  = '{1, 1, 1, 0, 1};
        tbl[6]  = '{1, 1, 1, 0, 1};
        tbl[7]  = '{1, 1, 0, 1, 0};
        tbl[8]  = '{1, 1, 1, 0, 1};
        tbl[9]  = '{1, 0, 1, 1, 0};
        tbl[10] = '{0, 0, 0, 0, 0};
        tbl[11] = '{0, 1, 0, 0, 1};
        tbl[12] = '{1, 1, 1, 0, 1};
        tbl[13] = '{1, 1, 0, 1, 0};

        reset = 1'b0; clr = 1'b0; r1_lock = 1'b0; fill_junk = 1'b1;
        set_req(0, 1, 0, 0, 0, 0, 0);
        set_req(1, 1, 0, 0, 0, 0, 0);
        model_reset();
        repeat (3) cyc();
        fill_junk = 1'b0;
        chk("rst_done", init_done, 1'b0);
        chk("rst_gnt", {r1_gnt, r0_gnt}, 2'b00);
        chk("rst_regwrite", rf_RegWrite, 1'b0);
        chk("rst_rvalid", {r1_rvalid, r0_rvalid}, 2'b00);
        chk("rst_rdata", r0_rdata1 | r1_rdata2, 64'd0);

        set_req(1, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        init_sweep();
        set_req(0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("post_init_regwrite", rf_RegWrite, 1'b0);

        for (int i = 0; i < 14; i++) begin
            set_req(0, tbl[i].r0, 0, 5'(i), 0, 0, 0);
            set_req(1, tbl[i].r1, 0, 0, 5'(i), 0, 0);
            r1_lock = tbl[i].lock;
            #1;
            chk("tbl_gnt0", r0_gnt, tbl[i].g0);
            chk("tbl_gnt1", r1_gnt, tbl[i].g1);
            model_step(win);
        end
        set_req(1, 0, 0, 0, 0, 0, 0);
        r1_lock = 1'b0;

        set_req(0, 1, 1, 0, 0, 5, 64'hDEAD_BEEF_0000_0001);
        model_step(win);
        set_req(0, 1, 0, 5, 0, 0, 0);
        model_step(win);
        chk("rw_rvalid", r0_rvalid, 1'b1);
        chk("rw_rdata1", r0_rdata1, 64'hDEAD_BEEF_0000_0001);
        chk("rw_rdata2", r0_rdata2, 64'd0);

        set_req(0, 0, 0, 0, 0, 0, 0);
        set_req(1, 1, 1, 0, 0, 0, 64'h1);
        #1;
        chk("x0_regwrite", rf_RegWrite, 1'b0);
        model_step(win);
        set_req(1, 0, 0, 0, 0, 0, 0);
        set_req(0, 1, 1, 7, 0, 7, 64'hA);
        model_step(win);
        chk("rbw_old", r0_rdata1, 64'd0);
        set_req(0, 1, 0, 7, 7, 0, 0);
        model_step(win);
        chk("rbw_new1", r0_rdata1, 64'hA);
        chk("rbw_new2", r0_rdata2, 64'hA);

        set_req(0, 1, 0, 7, 0, 0, 0);
        clr = 1'b1;
        #1;
        chk("clr_cycle_gnt", r0_gnt, 1'b0);
        chk("clr_cycle_we", rf_RegWrite, 1'b0);
        cyc();
        clr = 1'b0;
        chk("clr_cycle_rvalid", r0_rvalid, 1'b0);
        init_sweep();
        model_step(win);
        chk("x7_cleared", r0_rdata1, 64'd0);
        chk("x7_cleared_valid", r0_rvalid, 1'b1);

        clr = 1'b1;
        cyc();
        clr = 1'b0;
        repeat (11) cyc();
        #1;
        chk("mid_init_rd", rf_rd, 64'd12);
        reset = 1'b0;
        #1;
        chk("arst_regwrite", rf_RegWrite, 1'b0);
        chk("arst_gnt", r0_gnt, 1'b0);
        chk("arst_done", init_done, 1'b0);
        cyc();
        reset = 1'b1;
        model_reset();
        init_sweep();
        set_req(0, 0, 0, 0, 0, 0, 0);

        pend[0] = 1'b0;
        pend[1] = 1'b0;
        for (int c = 0; c < 400; c++) begin
            for (int w = 0; w < 2; w++) begin
                if (!pend[w] && $urandom_range(0, 1) == 1) begin
                    pend[w]  = 1'b1;
                    t_we[w]  = 1'($urandom_range(0, 1));
                    t_rs1[w] = 5'($urandom_range(0, 7));
                    t_rs2[w] = 5'($urandom_range(0, 7));
                    t_rd[w]  = 5'($urandom_range(0, 7));
                    t_wd[w]  = {$urandom, $urandom};
                end
                if (pend[w]) set_req(w, 1, t_we[w], t_rs1[w], t_rs2[w], t_rd[w], t_wd[w]);
                else set_req(w, 0, 1'($urandom_range(0, 1)), 5'($urandom), 5'($urandom),
                             5'($urandom), {$urandom, $urandom});
            end
            r1_lock = ($urandom_range(0, 2) == 0);
            model_step(win);
            if (win >= 0) pend[win] = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
